// File: rtl/duty_update_ctrl.sv
// -----------------------------------------------------------------------------
// duty_update_ctrl
//
// Purpose
//   Double-buffers host duty writes and commits them into the external 12-bit
//   duty holding register only at a safe point, so the PWM waveform generated
//   here from that register's readback never shows a torn period.
//   In mode 0 a pending duty is committed on the counter wrap. In mode 1 it is
//   committed on the next cycle.
//
// Ports
//   Clock         system clock, rising edge
//   Reset         synchronous, active-low
//   wr_valid      host offers a new duty value
//   wr_duty       duty value offered
//   wr_ready      controller can accept a write (registered)
//   upd_mode      0 = commit at period wrap, 1 = commit on next cycle
//   period        terminal count, sampled at wrap; period length = period+1
//   duty_q        readback of the committed duty register
//   duty_en       load enable to the duty register (combinational)
//   duty_din      load data to the duty register (the pending value)
//   period_start  one-cycle pulse in the cnt==0 cycle that follows a wrap
//   commit_done   one-cycle pulse in the cycle after duty_en
//   pwm_out       PWM output, registered: one cycle behind the counter
// -----------------------------------------------------------------------------
module duty_update_ctrl #(
  parameter int W = 12
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         wr_valid,
  input  logic [W-1:0] wr_duty,
  output logic         wr_ready,
  input  logic         upd_mode,
  input  logic [W-1:0] period,
  input  logic [W-1:0] duty_q,
  output logic         duty_en,
  output logic [W-1:0] duty_din,
  output logic         period_start,
  output logic         commit_done,
  output logic         pwm_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   pending_q;
  logic           wr_ready_q;
  logic           commit_done_q;

  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   per_lat_q, per_lat_d;
  logic           period_start_q;
  logic           pwm_q;

  logic           wrap;
  logic           commit;

  // ---------------------------------------------------------------------------
  // Period counter
  // ---------------------------------------------------------------------------
  // cnt never exceeds per_lat, so the equality test is the only terminal
  // condition needed. per_lat==0 degenerates to a wrap every cycle.
  assign wrap = (cnt_q == per_lat_q);

  // NOTE: every variable assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    cnt_d     = cnt_q + W'(1);
    per_lat_d = per_lat_q;
    if (wrap) begin
      cnt_d     = '0;
      per_lat_d = period;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q          <= '0;
      per_lat_q      <= '0;
      period_start_q <= 1'b0;
      pwm_q          <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      per_lat_q      <= per_lat_d;
      period_start_q <= wrap;
      pwm_q          <= (cnt_q < duty_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Write sequencer
  // ---------------------------------------------------------------------------
  // The commit condition is re-evaluated every PEND cycle, so a change of
  // upd_mode while a value is pending takes effect at once.
  assign commit = (state_q == PEND) && (upd_mode || wrap);

  // Gated by Reset so that a reset landing on a commit cycle cannot load the
  // duty register: the pending value is dropped, not committed.
  assign duty_en  = Reset && commit;
  assign duty_din = Reset ? pending_q : '0;

  // wr_ready is registered and cleared by reset, so it rises one cycle after
  // reset is released. Writes offered while it is low are simply not taken;
  // the host holds wr_valid until it sees wr_ready.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      wr_ready_q    <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      commit_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wr_valid && wr_ready_q) begin
            pending_q  <= wr_duty;
            wr_ready_q <= 1'b0;
            state_q    <= PEND;
          end else begin
            wr_ready_q <= 1'b1;
          end
        end
        PEND: begin
          // A write accepted in a wrap cycle lands here after that wrap, so it
          // waits for the next one in mode 0.
          if (commit) begin
            commit_done_q <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          wr_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          wr_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign wr_ready     = wr_ready_q;
  assign commit_done  = commit_done_q;
  assign period_start = period_start_q;
  assign pwm_out      = pwm_q;

endmodule

// File: tb/tb_duty_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_duty_update_ctrl
//
// Drives duty_update_ctrl with an external duty register closing the loop
// (duty_en/duty_din -> duty_q). Inputs change 1 time unit after the rising
// edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_duty_update_ctrl;

  localparam int W = 12;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         wr_valid;
  logic [W-1:0] wr_duty;
  logic         wr_ready;
  logic         upd_mode;
  logic [W-1:0] period;
  logic [W-1:0] duty_reg = '0;
  logic         duty_en;
  logic [W-1:0] duty_din;
  logic         period_start;
  logic         commit_done;
  logic         pwm_out;

  int n_checks = 0;
  int n_fail   = 0;

  duty_update_ctrl #(.W(W)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .wr_valid     (wr_valid),
    .wr_duty      (wr_duty),
    .wr_ready     (wr_ready),
    .upd_mode     (upd_mode),
    .period       (period),
    .duty_q       (duty_reg),
    .duty_en      (duty_en),
    .duty_din     (duty_din),
    .period_start (period_start),
    .commit_done  (commit_done),
    .pwm_out      (pwm_out)
  );

  always #5 Clock = ~Clock;

  // The duty holding register of the generator: not reset, loads on duty_en.
  always @(posedge Clock) if (duty_en) duty_reg <= duty_din;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    @(negedge Clock);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a one-entry write slot, a period position and the
  // committed duty. Updated at each rising edge from the inputs held there.
  // ---------------------------------------------------------------------------
  bit           mdl_on = 1'b0;
  int           m_cnt = 0, m_per = 0;
  int           m_duty = 0;
  int           m_last = 0;
  bit           m_ready = 1'b0, m_done = 1'b0, m_ps = 1'b0, m_pwm = 1'b0;
  int           slot[$];

  always @(posedge Clock) begin
    if (!Reset) begin
      m_cnt = 0; m_per = 0; m_ps = 0; m_pwm = 0;
      slot.delete();
      m_ready = 0; m_done = 0; m_last = 0;
    end else begin
      bit at_end, take;
      at_end = (m_cnt == m_per);
      take   = (slot.size() != 0) && (upd_mode || at_end);
      m_pwm  = (m_cnt < m_duty);
      m_ps   = at_end;
      m_cnt  = at_end ? 0 : m_cnt + 1;
      if (at_end) m_per = int'(period);
      m_done = take;
      if (take) m_duty = slot.pop_front();
      else if (m_ready && wr_valid) begin
        slot.push_back(int'(wr_duty));
        m_last = int'(wr_duty);
      end
      m_ready = (slot.size() == 0) && !m_done;
    end
  end

  always @(negedge Clock) begin
    if (mdl_on) begin
      bit exp_en;
      exp_en = Reset && (slot.size() != 0) && (upd_mode || m_cnt == m_per);
      check("mdl_wr_ready",     32'(wr_ready),     32'(m_ready));
      check("mdl_duty_en",      32'(duty_en),      32'(exp_en));
      check("mdl_duty_din",     32'(duty_din),     Reset ? m_last : 0);
      check("mdl_period_start", 32'(period_start), 32'(m_ps));
      check("mdl_commit_done",  32'(commit_done),  32'(m_done));
      check("mdl_pwm_out",      32'(pwm_out),      32'(m_pwm));
      check("mdl_duty_reg",     32'(duty_reg),     m_duty);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors after reset release: one row per cycle.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic         rst_n;
    logic         valid;
    logic [W-1:0] duty;
    logic         mode;
    logic [W-1:0] per;
    logic         e_ready;
    logic         e_en;
    logic [W-1:0] e_din;
    logic         e_done;
    logic         e_ps;
    logic         e_pwm;
  } vec_t;

  vec_t tbl[10];

  task automatic host_write(input logic [W-1:0] d, output bit ok);
    int n = 0;
    next_cycle();
    while (!wr_ready && n < 50) begin
      next_cycle();
      n++;
    end
    ok       = wr_ready;
    wr_valid = ok;
    wr_duty  = d;
    next_cycle();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      settle();
      if (commit_done) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
  endtask

  initial begin
    bit ok;
    int hi_a, hi_b;

    tbl[0] = '{1'b1, 1'b0, 12'd0, 1'b0, 12'd2, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 12'd5, 1'b1, 12'd2, 1'b1, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 12'd0, 1'b1, 12'd2, 1'b0, 1'b1, 12'd5, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 12'd1, 1'b1, 12'd2, 1'b0, 1'b0, 12'd5, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 12'd1, 1'b0, 12'd2, 1'b1, 1'b0, 12'd5, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 12'd0, 1'b0, 12'd2, 1'b0, 1'b0, 12'd1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 12'd0, 1'b0, 12'd2, 1'b0, 1'b1, 12'd1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 12'd0, 1'b0, 12'd2, 1'b0, 1'b0, 12'd1, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 12'd0, 1'b0, 12'd2, 1'b1, 1'b0, 12'd1, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 12'd0, 1'b0, 12'd2, 1'b1, 1'b0, 12'd1, 1'b0, 1'b0, 1'b0};

    // Reset held low for three edges: everything reads 0.
    Reset = 1'b0; wr_valid = 1'b0; wr_duty = '0; upd_mode = 1'b0; period = 12'd2;
    repeat (3) @(posedge Clock);
    settle();
    check("rst_wr_ready",     32'(wr_ready),     0);
    check("rst_duty_en",      32'(duty_en),      0);
    check("rst_duty_din",     32'(duty_din),     0);
    check("rst_period_start", 32'(period_start), 0);
    check("rst_commit_done",  32'(commit_done),  0);
    check("rst_pwm_out",      32'(pwm_out),      0);
    mdl_on = 1'b1;

    for (int r = 0; r < 10; r++) begin
      next_cycle();
      Reset = tbl[r].rst_n; wr_valid = tbl[r].valid; wr_duty = tbl[r].duty;
      upd_mode = tbl[r].mode; period = tbl[r].per;
      settle();
      check($sformatf("tbl%0d_ready", r), 32'(wr_ready),     32'(tbl[r].e_ready));
      check($sformatf("tbl%0d_en", r),    32'(duty_en),      32'(tbl[r].e_en));
      check($sformatf("tbl%0d_din", r),   32'(duty_din),     32'(tbl[r].e_din));
      check($sformatf("tbl%0d_done", r),  32'(commit_done),  32'(tbl[r].e_done));
      check($sformatf("tbl%0d_ps", r),    32'(period_start), 32'(tbl[r].e_ps));
      check($sformatf("tbl%0d_pwm", r),   32'(pwm_out),      32'(tbl[r].e_pwm));
    end

    // period=9, mode 0: write 3 at cnt=4, then a held second write of 7.
    next_cycle();
    wr_valid = 1'b0; upd_mode = 1'b0; period = 12'd9;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      next_cycle();
      settle();
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("sync_period_start", 32'(ok), 1);

    hi_a = 0; hi_b = 0;
    for (int i = 1; i <= 40; i++) begin
      bit e_ready;
      next_cycle();
      wr_valid = (i >= 4 && i <= 11);
      wr_duty  = (i == 4) ? 12'd3 : 12'd7;
      settle();
      if (i == 4) check("p9_ready_at_cnt4", 32'(wr_ready), 1);
      if (i >= 5) begin
        e_ready = (i == 11) || (i >= 21);
        check($sformatf("p9_en_i%0d", i),    32'(duty_en),      32'(i == 9 || i == 19));
        check($sformatf("p9_ready_i%0d", i), 32'(wr_ready),     32'(e_ready));
        check($sformatf("p9_done_i%0d", i),  32'(commit_done),  32'(i == 10 || i == 20));
        check($sformatf("p9_ps_i%0d", i),    32'(period_start), 32'(i % 10 == 0));
      end
      if (i == 9)  check("p9_din_first",  32'(duty_din), 3);
      if (i == 19) check("p9_din_second", 32'(duty_din), 7);
      if (i >= 11 && i <= 20 && pwm_out) hi_a++;
      if (i >= 21 && i <= 30 && pwm_out) hi_b++;
    end
    check("p9_pwm_high_duty3", hi_a, 3);
    check("p9_pwm_high_duty7", hi_b, 7);

    // Extremes: duty 0 never high, duty above the period always high.
    upd_mode = 1'b1;
    host_write(12'd0, ok);  check("wr0_accept", 32'(ok), 1);
    wait_done(ok);          check("wr0_done",   32'(ok), 1);
    repeat (2) next_cycle();
    for (int i = 0; i < 20; i++) begin
      next_cycle(); settle();
      check("pwm_duty0", 32'(pwm_out), 0);
    end
    host_write(12'd12, ok); check("wr12_accept", 32'(ok), 1);
    wait_done(ok);          check("wr12_done",   32'(ok), 1);
    repeat (2) next_cycle();
    for (int i = 0; i < 20; i++) begin
      next_cycle(); settle();
      check("pwm_duty12", 32'(pwm_out), 1);
    end

    // Mode 1: duty_en the cycle after accept, commit_done the cycle after.
    host_write(12'd5, ok);  check("wr5_accept", 32'(ok), 1);
    settle();
    check("m1_en",        32'(duty_en),     1);
    check("m1_din",       32'(duty_din),    5);
    check("m1_done_early", 32'(commit_done), 0);
    next_cycle(); settle();
    check("m1_en_once",   32'(duty_en),     0);
    check("m1_done",      32'(commit_done), 1);
    check("m1_ready_low", 32'(wr_ready),    0);
    next_cycle(); settle();
    check("m1_ready_back", 32'(wr_ready),   1);
    check("m1_duty_reg",  32'(duty_reg),    5);

    // Reset while a mode-0 write is pending: nothing is committed.
    upd_mode = 1'b0;
    host_write(12'd9, ok);  check("wr9_accept", 32'(ok), 1);
    Reset = 1'b0;
    settle();
    check("rp_en_0", 32'(duty_en), 0);
    next_cycle(); settle();
    check("rp_en_1",    32'(duty_en),  0);
    check("rp_ready_1", 32'(wr_ready), 0);
    next_cycle();
    Reset = 1'b1;
    settle();
    check("rp_ready_release", 32'(wr_ready), 0);
    next_cycle(); settle();
    check("rp_ready_idle", 32'(wr_ready), 1);
    for (int i = 0; i < 25; i++) begin
      next_cycle(); settle();
      check("rp_no_commit", 32'(duty_en),  0);
      check("rp_duty_kept", 32'(duty_reg), 5);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 1200; i++) begin
      next_cycle();
      Reset    = ($urandom_range(0, 99) != 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_duty  = W'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) upd_mode = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 39) == 0) period = W'($urandom_range(0, 7));
    end
    next_cycle();
    Reset = 1'b1;
    settle();
    mdl_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
